// File: rtl/spi_host_arbiter_pkg.sv
// spi_arb_pkg: state encoding, width helper and default constants for spi_host_arbiter
package spi_arb_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_DONE = 3'd2,
        WAIT_RX   = 3'd3,
        RELEASE   = 3'd4
    } state_e;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/spi_host_arbiter_if.sv
// spi_host_arbiter_if: client request/response bus plus SPI host handshake
interface spi_host_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          err;
    logic                          busy;
    logic [DATA_WIDTH-1:0]         host_tx_data;
    logic                          host_tx_start;
    logic                          host_tx_done;
    logic [DATA_WIDTH-1:0]         host_rx_data;
    logic                          host_rx_valid;
    modport master (
        input  req, req_data, host_tx_done, host_rx_data, host_rx_valid,
        output grant, done, rsp_data, err, busy, host_tx_data, host_tx_start
    );
    modport slave (
        output req, req_data, host_tx_done, host_rx_data, host_rx_valid,
        input  grant, done, rsp_data, err, busy, host_tx_data, host_tx_start
    );
endinterface

// File: rtl/spi_host_arbiter_picker.sv
// spi_rr_picker: rotating-priority encoder; the first set req at or above ptr (wrapping) wins
module spi_rr_picker import spi_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot,
    output logic               any_req
);
    // scan from lowest priority to highest so the closest-to-ptr request overwrites last
    always_comb begin
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            idx = req[PTR_W'((int'(ptr) + k) % NUM_REQ)] ? PTR_W'((int'(ptr) + k) % NUM_REQ) : idx;
    end
    assign any_req = |req;
    assign onehot  = any_req ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/spi_host_arbiter.sv
// spi_host_arbiter: round-robin sharing of one SPI host between NUM_REQ clients
// SPI_ARB_TIMEOUT_EN adds a watchdog forcing RELEASE with err after TIMEOUT_CYCLES
module spi_host_arbiter import spi_arb_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
`ifdef SPI_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input logic                clk,
    input logic                rst,
    spi_host_arbiter_if.master bus
);
    localparam int PTR_W = ptr_w(NUM_REQ);
    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d, done_q, done_d, pick_oh;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rsp_q, rsp_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d, win_q, win_d, pick_idx;
    logic                  pick_any;
    spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (bus.req),
        .ptr     (ptr_q),
        .idx     (pick_idx),
        .onehot  (pick_oh),
        .any_req (pick_any)
    );
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d, waiting, expired;
    assign waiting = (state_q == WAIT_DONE) || (state_q == WAIT_RX);
    assign expired = waiting && (cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES));
    always_comb begin
        cnt_d = waiting ? cnt_q + 1'b1 : '0;
        err_d = expired;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        tx_d    = tx_q;
        rsp_d   = rsp_q;
        done_d  = '0;
        win_d   = win_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (pick_any) begin
                state_d = START;
                grant_d = pick_oh;
                win_d   = pick_idx;
                tx_d    = bus.req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            START:     state_d = WAIT_DONE;
            WAIT_DONE: state_d = bus.host_tx_done ? WAIT_RX : WAIT_DONE;
            WAIT_RX: if (bus.host_rx_valid) begin
                state_d = RELEASE;
                rsp_d   = bus.host_rx_data;
                done_d  = grant_q;
            end
            RELEASE: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
`ifdef SPI_ARB_TIMEOUT_EN
        if (expired) begin
            state_d = RELEASE;
            rsp_d   = '0;
            done_d  = grant_q;
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            tx_q    <= '0;
            rsp_q   <= '0;
            win_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
            rsp_q   <= rsp_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
        end
    end
    assign bus.grant         = grant_q;
    assign bus.done          = done_q;
    assign bus.rsp_data      = rsp_q;
    assign bus.host_tx_data  = tx_q;
    assign bus.host_tx_start = (state_q == START);
    assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_spi_host_arbiter.sv
// tb_spi_host_arbiter: directed checks of spi_host_arbiter against a simple host stub
module tb_spi_host_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_start = 0;
    int         s0;
    bit         stub_en = 1'b1;
    bit         stub_inv = 1'b0;
    logic [7:0] stub_byte = 8'h00;
    logic [7:0] stub_txd;
    logic       saw;
    int         n;

    spi_host_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    spi_host_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(8)
`ifdef SPI_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.host_tx_start === 1'b1) n_start++;

    // host stub: tx_done two cycles into WAIT_DONE, rx_valid the cycle after
    initial begin
        bus.host_tx_done  = 1'b0;
        bus.host_rx_valid = 1'b0;
        bus.host_rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (stub_en && bus.host_tx_start === 1'b1) begin
                stub_txd = bus.host_tx_data;
                repeat (2) @(negedge clk);
                bus.host_tx_done = 1'b1;
                @(negedge clk);
                bus.host_tx_done  = 1'b0;
                bus.host_rx_valid = 1'b1;
                bus.host_rx_data  = stub_inv ? ~stub_txd : stub_byte;
                @(negedge clk);
                bus.host_rx_valid = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [3:0] exp_g, input logic [7:0] exp_rsp,
                             input logic [3:0] drop);
        int k = 0;
        while (bus.done === 4'b0000 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_in_time"}, 32'(k < 60), 32'd1);
        chk({tag, "_done"}, 32'(bus.done), 32'(exp_g));
        chk({tag, "_rsp"}, 32'(bus.rsp_data), 32'(exp_rsp));
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        bus.req = bus.req & ~drop;
        @(negedge clk);
        chk({tag, "_after"}, {23'd0, bus.done, bus.grant, bus.busy}, 32'd0);
    endtask

    initial begin
        bus.req      = 4'b0000;
        bus.req_data = 32'h0;
        do_reset();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_start", 32'(bus.host_tx_start), 32'd0);
        chk("rst_rsp", 32'(bus.rsp_data), 32'd0);
        chk("rst_txd", 32'(bus.host_tx_data), 32'd0);

        // single client, fixed stub reply; late req_data change must be ignored
        stub_inv = 1'b0;
        stub_byte = 8'h3C;
        bus.req_data[23:16] = 8'hA5;
        s0 = n_start;
        bus.req = 4'b0100;
        @(negedge clk);
        chk("t1_grant", 32'(bus.grant), 32'h4);
        chk("t1_start", 32'(bus.host_tx_start), 32'd1);
        chk("t1_txd", 32'(bus.host_tx_data), 32'hA5);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        bus.req_data[23:16] = 8'hFF;
        @(negedge clk);
        chk("t1_start_once", 32'(bus.host_tx_start), 32'd0);
        chk("t1_txd_stable", 32'(bus.host_tx_data), 32'hA5);
        wait_done("t1", 4'b0100, 8'h3C, 4'b0100);
        chk("t1_rsp_held", 32'(bus.rsp_data), 32'h3C);
        chk("t1_nstart", 32'(n_start - s0), 32'd1);

        // all four requesting from a fresh pointer
        do_reset();
        stub_inv = 1'b1;
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        s0 = n_start;
        bus.req = 4'b1111;
        wait_done("t2_c0", 4'b0001, 8'hEF, 4'b0001);
        wait_done("t2_c1", 4'b0010, 8'hEE, 4'b0010);
        wait_done("t2_c2", 4'b0100, 8'hED, 4'b0100);
        wait_done("t2_c3", 4'b1000, 8'hEC, 4'b1000);
        chk("t2_nstart", 32'(n_start - s0), 32'd4);

        // two clients contending continuously alternate
        do_reset();
        bus.req_data = {8'h00, 8'h00, 8'h21, 8'h20};
        bus.req = 4'b0011;
        for (int i = 0; i < 6; i++)
            wait_done($sformatf("t3_%0d", i), (i % 2) ? 4'b0010 : 4'b0001,
                      (i % 2) ? 8'hDE : 8'hDF, (i == 5) ? 4'b0011 : 4'b0000);

        // byte routing to the right client
        do_reset();
        bus.req_data = {8'h7E, 8'h00, 8'h81, 8'h00};
        bus.req = 4'b1010;
        wait_done("t4_c1", 4'b0010, 8'h7E, 4'b0010);
        wait_done("t4_c3", 4'b1000, 8'h81, 4'b1000);

        // reset while waiting on the host abandons the transfer
        stub_en = 1'b0;
        bus.req = 4'b0100;
        @(negedge clk);
        chk("t5_start", 32'(bus.host_tx_start), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t5_waiting", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_grant", 32'(bus.grant), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw = saw | (|bus.done);
            @(negedge clk);
        end
        chk("t5_no_done", 32'(saw), 32'd0);
        stub_en = 1'b1;
        bus.req = 4'b1000;
        @(negedge clk);
        chk("t5_regrant", 32'(bus.grant), 32'h8);
        wait_done("t5_c3", 4'b1000, 8'h81, 4'b1000);

`ifdef SPI_ARB_TIMEOUT_EN
        // silent host: watchdog releases client 0 with err, client 1 is served next
        do_reset();
        stub_en = 1'b0;
        bus.req_data = {8'h00, 8'h00, 8'h55, 8'h44};
        bus.req = 4'b0011;
        @(negedge clk);
        chk("tmo_start", 32'(bus.host_tx_start), 32'd1);
        n = 0;
        while (bus.done === 4'b0000 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", 32'(n), 32'd17);
        chk("tmo_done", 32'(bus.done), 32'h1);
        chk("tmo_err", 32'(bus.err), 32'd1);
        chk("tmo_rsp", 32'(bus.rsp_data), 32'd0);
        stub_en = 1'b1;
        bus.req = 4'b0010;
        @(negedge clk);
        chk("tmo_err_pulse", {30'd0, bus.err, |bus.done}, 32'd0);
        wait_done("tmo_c1", 4'b0010, 8'hAA, 4'b0010);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
